vx_fpu_csr_slice: RTL and testbench

- Responder end of the FPU-to-CSR interface: holds per-warp floating-point CSR state (frm, fflags).
- Serves combinational dynamic-rounding-mode lookups for the FPU unit.
- OR-accumulates FPU-reported exception flags.
- Executes CSR-instruction accesses to fflags/frm/fcsr. Tracks per-warp outstanding FPU operations so that fflags/fcsr accesses stall until every in-flight FPU op of that warp has retired.

---
 rtl/vx_fpu_csr_slice.sv | 156 +++++++++++++++
 tb/tb_vx_fpu_csr_slice.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fpu_csr_slice.sv
// vx_fpu_csr_slice: per-warp FP CSR state (frm, fflags) serving
// FPU rounding-mode lookups, flag accumulation and CSR accesses.
module vx_fpu_csr_slice #(
   parameter int NUM_WARPS  = 4,
   parameter int NW_WIDTH   = 2,
   parameter int PEND_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NW_WIDTH-1:0]  read_wid,
   output logic [2:0]           read_frm,
   input  logic                 write_enable,
   input  logic [NW_WIDTH-1:0]  write_wid,
   input  logic [4:0]           write_fflags,
   input  logic                 issue_valid,
   input  logic [NW_WIDTH-1:0]  issue_wid,
   input  logic                 retire_valid,
   input  logic [NW_WIDTH-1:0]  retire_wid,
   output logic [NUM_WARPS-1:0] pend_full,
   input  logic                 csr_req_valid,
   output logic                 csr_req_ready,
   input  logic [NW_WIDTH-1:0]  csr_req_wid,
   input  logic [11:0]          csr_req_addr,
   input  logic [1:0]           csr_req_op,
   input  logic [31:0]          csr_req_data,
   output logic                 csr_rsp_valid,
   input  logic                 csr_rsp_ready,
   output logic [31:0]          csr_rsp_data
);

   logic [2:0]            frm_q    [NUM_WARPS];
   logic [4:0]            fflags_q [NUM_WARPS];
   logic [PEND_WIDTH-1:0] pend_q   [NUM_WARPS];
   logic [2:0]            frm_n    [NUM_WARPS];
   logic [4:0]            fflags_n [NUM_WARPS];
   logic [PEND_WIDTH-1:0] pend_n   [NUM_WARPS];
   logic [NUM_WARPS-1:0]  inc, dec;

   logic        is_ff, is_frm, is_fcsr;
   logic        stall, accept;
   logic [2:0]  old_frm;
   logic [4:0]  old_ff;
   logic [7:0]  old_sel, upd_val;
   logic [31:0] rsp_val;
   logic        unused_data;

   function automatic logic [7:0] csr_upd(
      input logic [7:0] old,
      input logic [7:0] d,
      input logic [1:0] op
   );
      logic [7:0] r;
      unique case (op)
         2'd0: r = old;
         2'd1: r = d;
         2'd2: r = old | d;
         2'd3: r = old & ~d;
         default: r = old;
      endcase
      return r;
   endfunction

   assign unused_data = ^csr_req_data[31:8];

   always_comb begin
      is_ff   = (csr_req_addr == 12'h001);
      is_frm  = (csr_req_addr == 12'h002);
      is_fcsr = (csr_req_addr == 12'h003);
      old_frm = frm_q[csr_req_wid];
      old_ff  = fflags_q[csr_req_wid];
      stall   = (is_ff | is_fcsr) &&
                (pend_q[csr_req_wid] != '0);
      csr_req_ready = ~stall &
                      (~csr_rsp_valid | csr_rsp_ready);
      accept  = csr_req_valid & csr_req_ready;
      old_sel = {old_frm, old_ff};
      rsp_val = '0;
      unique case (1'b1)
         is_ff: begin
            old_sel = {3'b0, old_ff};
            rsp_val = {27'b0, old_ff};
         end
         is_frm: begin
            old_sel = {5'b0, old_frm};
            rsp_val = {29'b0, old_frm};
         end
         is_fcsr: rsp_val = {24'b0, old_ff, old_frm} ;
         default: ;
      endcase
      if (is_fcsr) rsp_val = {24'b0, old_frm, old_ff};
      upd_val = csr_upd(old_sel, csr_req_data[7:0],
                        csr_req_op);
   end

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         frm_n[w]    = frm_q[w];
         fflags_n[w] = fflags_q[w];
         pend_n[w]   = pend_q[w];
         inc[w] = issue_valid &&
                  (issue_wid == NW_WIDTH'(w));
         dec[w] = retire_valid &&
                  (retire_wid == NW_WIDTH'(w));
         if (accept && csr_req_wid == NW_WIDTH'(w)) begin
            if (is_frm)  frm_n[w] = upd_val[2:0];
            if (is_fcsr) frm_n[w] = upd_val[7:5];
            if (is_ff | is_fcsr)
               fflags_n[w] = upd_val[4:0];
         end
         // FPU flags merge after the CSR update so none are lost
         if (write_enable && write_wid == NW_WIDTH'(w))
            fflags_n[w] = fflags_n[w] | write_fflags;
         if (inc[w] && !dec[w] && !(&pend_q[w]))
            pend_n[w] = pend_q[w] + 1'b1;
         else if (dec[w] && !inc[w] && pend_q[w] != '0)
            pend_n[w] = pend_q[w] - 1'b1;
         pend_full[w] = &pend_q[w];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            frm_q[w]    <= '0;
            fflags_q[w] <= '0;
            pend_q[w]   <= '0;
         end
         csr_rsp_valid <= 1'b0;
         csr_rsp_data  <= '0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            frm_q[w]    <= frm_n[w];
            fflags_q[w] <= fflags_n[w];
            pend_q[w]   <= pend_n[w];
         end
         if (accept) begin
            csr_rsp_valid <= 1'b1;
            csr_rsp_data  <= rsp_val;
         end else if (csr_rsp_ready) begin
            csr_rsp_valid <= 1'b0;
         end
      end
   end

   assign read_frm = frm_q[read_wid];

   for (genvar g = 0; g < NUM_WARPS; g++) begin : g_chk
      a_no_ovf: assert property (@(posedge clk)
         disable iff (reset)
         !(inc[g] && !dec[g] && (&pend_q[g])));
      a_no_unf: assert property (@(posedge clk)
         disable iff (reset)
         !(dec[g] && !inc[g] && pend_q[g] == '0));
   end

endmodule

// File: tb/tb_vx_fpu_csr_slice.sv
// tb_vx_fpu_csr_slice: directed stimulus with a response
// scoreboard for vx_fpu_csr_slice.
module tb_vx_fpu_csr_slice;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  read_wid;
   logic [2:0]  read_frm;
   logic        write_enable;
   logic [1:0]  write_wid;
   logic [4:0]  write_fflags;
   logic        issue_valid;
   logic [1:0]  issue_wid;
   logic        retire_valid;
   logic [1:0]  retire_wid;
   logic [3:0]  pend_full;
   logic        csr_req_valid;
   logic        csr_req_ready;
   logic [1:0]  csr_req_wid;
   logic [11:0] csr_req_addr;
   logic [1:0]  csr_req_op;
   logic [31:0] csr_req_data;
   logic        csr_rsp_valid;
   logic        csr_rsp_ready;
   logic [31:0] csr_rsp_data;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   vx_fpu_csr_slice #(
      .NUM_WARPS(4), .NW_WIDTH(2), .PEND_WIDTH(4)
   ) dut (
      .clk(clk), .reset(reset),
      .read_wid(read_wid), .read_frm(read_frm),
      .write_enable(write_enable),
      .write_wid(write_wid),
      .write_fflags(write_fflags),
      .issue_valid(issue_valid), .issue_wid(issue_wid),
      .retire_valid(retire_valid),
      .retire_wid(retire_wid),
      .pend_full(pend_full),
      .csr_req_valid(csr_req_valid),
      .csr_req_ready(csr_req_ready),
      .csr_req_wid(csr_req_wid),
      .csr_req_addr(csr_req_addr),
      .csr_req_op(csr_req_op),
      .csr_req_data(csr_req_data),
      .csr_rsp_valid(csr_rsp_valid),
      .csr_rsp_ready(csr_rsp_ready),
      .csr_rsp_data(csr_rsp_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && csr_rsp_valid && csr_rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got 0x%0h",
                     csr_rsp_data);
         end else begin
            chk("rsp_data", csr_rsp_data, exp_q.pop_front());
         end
      end
   end

   task automatic drive_req(input int w, input int a,
                            input int op,
                            input logic [31:0] d);
      csr_req_valid = 1'b1;
      csr_req_wid   = 2'(w);
      csr_req_addr  = 12'(a);
      csr_req_op    = 2'(op);
      csr_req_data  = d;
   endtask

   task automatic csr(input int w, input int a,
                      input int op, input logic [31:0] d,
                      input logic [31:0] exp);
      bit done = 0;
      drive_req(w, a, op, d);
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (csr_req_ready) begin
            exp_q.push_back(exp);
            done = 1;
         end
         @(posedge clk); #1;
      end
      csr_req_valid = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL csr_accept_timeout: wid %0d addr %0h",
                  w, a);
      end else begin
         @(negedge clk);
         chk("rsp_latency", 32'(csr_rsp_valid), 1);
         @(posedge clk); #1;
      end
   endtask

   task automatic issue(input int w);
      issue_valid = 1'b1;
      issue_wid   = 2'(w);
      @(posedge clk); #1;
      issue_valid = 1'b0;
   endtask

   task automatic retire(input int w, input logic [4:0] f);
      retire_valid = 1'b1;
      retire_wid   = 2'(w);
      write_enable = 1'b1;
      write_wid    = 2'(w);
      write_fflags = f;
      @(posedge clk); #1;
      retire_valid = 1'b0;
      write_enable = 1'b0;
   endtask

   task automatic fpu_write(input int w, input logic [4:0] f);
      write_enable = 1'b1;
      write_wid    = 2'(w);
      write_fflags = f;
      @(posedge clk); #1;
      write_enable = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      read_wid = '0;
      write_enable = 0; write_wid = '0; write_fflags = '0;
      issue_valid = 0; issue_wid = '0;
      retire_valid = 0; retire_wid = '0;
      csr_req_valid = 0; csr_req_wid = '0;
      csr_req_addr = '0; csr_req_op = '0; csr_req_data = '0;
      csr_rsp_ready = 1'b1;
      #2;
      chk("reset_rsp_valid", 32'(csr_rsp_valid), 0);
      chk("reset_rsp_data", csr_rsp_data, 0);
      chk("reset_pend_full", 32'(pend_full), 0);
      for (int i = 0; i < 4; i++) begin
         read_wid = 2'(i);
         #1;
         chk("reset_read_frm", 32'(read_frm), 0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      csr(2, 3, 0, 0, 32'h00);

      csr(1, 2, 1, 3, 32'h0);
      read_wid = 2'd1;
      @(negedge clk);
      chk("read_frm_w1", 32'(read_frm), 3);
      read_wid = 2'd0;
      #1;
      chk("read_frm_w0", 32'(read_frm), 0);
      @(posedge clk); #1;

      issue(0);
      issue(0);
      drive_req(0, 1, 0, 0);
      @(negedge clk);
      chk("stall_ready", 32'(csr_req_ready), 0);
      @(posedge clk); #1;
      fork
         csr(0, 1, 0, 0, 32'h05);
         begin
            retire(0, 5'h01);
            retire(0, 5'h04);
         end
      join

      csr(0, 1, 2, 32'h02, 32'h05);
      csr(0, 1, 0, 0, 32'h07);

      csr(3, 1, 1, 32'h1F, 32'h00);
      fork
         csr(3, 1, 3, 32'h1F, 32'h1F);
         fpu_write(3, 5'h02);
      join
      csr(3, 1, 0, 0, 32'h02);

      for (int i = 0; i < 15; i++) issue(1);
      @(negedge clk);
      chk("pend_full_set", 32'(pend_full), 32'h2);
      @(posedge clk); #1;
      issue_valid = 1; issue_wid = 2'd1;
      retire_valid = 1; retire_wid = 2'd1;
      @(posedge clk); #1;
      issue_valid = 0; retire_valid = 0;
      @(negedge clk);
      chk("pend_full_hold", 32'(pend_full), 32'h2);
      @(posedge clk); #1;
      retire(1, 5'h00);
      @(negedge clk);
      chk("pend_full_clr", 32'(pend_full), 0);
      @(posedge clk); #1;
      csr(1, 2, 0, 0, 32'h3);
      drive_req(1, 3, 0, 0);
      @(negedge clk);
      chk("fcsr_stall", 32'(csr_req_ready), 0);
      @(posedge clk); #1;
      csr_req_valid = 0;

      csr(2, 3, 1, 32'hFFFF_FFA5, 32'h00);
      csr(2, 12'h7FF, 1, 32'hFF, 32'h0);
      csr(2, 3, 0, 0, 32'hA5);

      csr_rsp_ready = 1'b0;
      csr(2, 3, 0, 0, 32'hA5);
      drive_req(2, 2, 0, 0);
      @(negedge clk);
      chk("bp_ready0", 32'(csr_req_ready), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_ready1", 32'(csr_req_ready), 0);
      @(posedge clk); #1;
      csr_rsp_ready = 1'b1;
      csr(2, 2, 0, 0, 32'h5);

      csr_rsp_ready = 1'b0;
      drive_req(2, 2, 0, 0);
      @(negedge clk);
      chk("pre_rst_ready", 32'(csr_req_ready), 1);
      @(posedge clk); #1;
      csr_req_valid = 0;
      @(negedge clk);
      chk("pre_rst_valid", 32'(csr_rsp_valid), 1);
      chk("pre_rst_data", csr_rsp_data, 32'h5);
      #1 reset = 1'b1;
      #1;
      chk("rst_drop_valid", 32'(csr_rsp_valid), 0);
      chk("rst_drop_data", csr_rsp_data, 0);
      read_wid = 2'd1;
      #1;
      chk("rst_read_frm", 32'(read_frm), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      csr_rsp_ready = 1'b1;
      csr(2, 3, 0, 0, 32'h0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         @(posedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
